temp_to_seg: RTL

- Sits between the DS18B20 read controller and `seg_driver`.
- Takes a raw 16-bit DS18B20 temperature word (two's complement, 1/16 °C per LSB) on a valid pulse.
- Converts it with a sequential shift-add datapath to a 6-digit fixed-point magnitude with 3 decimals (`seg_value`, 0..125000) plus an active-low decimal-point pattern (`dot`).
- Outputs hold until the next conversion completes.

---
 rtl/temp_to_seg_if.sv | 34 +++
 rtl/temp_to_seg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/temp_to_seg_if.sv
// ---------------------------------------------------------------------------
// temp_to_seg_if
//   Signal bundle between the DS18B20 read controller (master) and the
//   temp_to_seg converter (slave).
//
//   temp_raw  [15:0]  raw DS18B20 word, two's complement, 1/16 degC per LSB
//   temp_vld          single-cycle sample strobe
//   seg_value [24:0]  |T| x 1000, unsigned, for seg_driver
//   dot       [5:0]   active-low decimal points, dot[5] = rightmost digit
//   neg               last converted sample was below 0 degC
//   err               last sample exceeded the clamp and was saturated
//   busy              conversion in progress, new strobes are dropped
//   upd               one-cycle pulse when the outputs are refreshed
// ---------------------------------------------------------------------------
interface temp_to_seg_if;
    logic [15:0] temp_raw;
    logic        temp_vld;
    logic [24:0] seg_value;
    logic [5:0]  dot;
    logic        neg;
    logic        err;
    logic        busy;
    logic        upd;

    modport master (
        output temp_raw, temp_vld,
        input  seg_value, dot, neg, err, busy, upd
    );

    modport slave (
        input  temp_raw, temp_vld,
        output seg_value, dot, neg, err, busy, upd
    );
endinterface

// File: rtl/temp_to_seg.sv
// ---------------------------------------------------------------------------
// temp_to_seg
//   Converts a raw DS18B20 temperature word into a 6-digit fixed-point
//   magnitude with three decimals (ddd.ddd) for seg_driver. The conversion
//   is |raw| x 62.5 (truncated), computed as |raw| x 125 with a sequential
//   MSB-first shift-add and a final drop of the LSB.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    temp_to_seg_if.slave (temp_raw/temp_vld in; seg_value, dot,
//            neg, err, busy, upd out)
//   Parameters:
//     MAG_MAX  magnitude clamp in 1/16 degC LSBs (2000 = 125 degC)
//   Optional feature:
//     TEMP_AVG_EN  when defined, a 4-sample running average is converted
//                  instead of the raw sample (adds one cycle of latency).
// ---------------------------------------------------------------------------
module temp_to_seg #(
    parameter int MAG_MAX = 2000
) (
    input  logic          clk,
    input  logic          rst_n,
    temp_to_seg_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AVG,
        S_ABS,
        S_MUL,
        S_OUT
    } state_t;

    // Multiplier constant 125, walked MSB first.
    localparam logic [6:0]  K_COEF    = 7'b1111101;
    localparam logic [16:0] MAG_MAX_W = 17'(MAG_MAX);

    state_t       state_reg, state_next;
    logic [15:0]  raw_reg;
    logic [10:0]  mag_reg;
    logic [17:0]  acc_reg;
    logic [2:0]   cnt_reg;
    logic         neg_pend_reg;
    logic         err_pend_reg;

    logic [24:0]  seg_value_reg;
    logic [5:0]   dot_reg;
    logic         neg_reg;
    logic         err_reg;
    logic         busy_reg;
    logic         upd_reg;

    logic         accept;
    logic [16:0]  raw_ext;
    logic [16:0]  mag_full;
    logic         over;
    logic [17:0]  acc_step;

    // Samples are taken only in IDLE; strobes in any other state are lost.
    assign accept = (state_reg == S_IDLE) && bus.temp_vld;

    // 17-bit magnitude so that 0x8000 becomes +32768 rather than wrapping.
    assign raw_ext  = {raw_reg[15], raw_reg};
    assign mag_full = raw_reg[15] ? (17'd0 - raw_ext) : raw_ext;
    assign over     = (mag_full > MAG_MAX_W);

    assign acc_step = {acc_reg[16:0], 1'b0}
                    + (K_COEF[cnt_reg] ? {7'd0, mag_reg} : 18'd0);

`ifdef TEMP_AVG_EN
    logic signed [15:0] hist_reg [4];
    logic               hist_full_reg;
    logic [1:0]         wr_ptr_reg;
    logic signed [17:0] hist_sum;

    assign hist_sum = 18'(hist_reg[0]) + 18'(hist_reg[1])
                    + 18'(hist_reg[2]) + 18'(hist_reg[3]);

    // The first accepted sample seeds every entry so the average starts
    // at that value instead of ramping up from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hist_reg[i] <= '0;
            end
            hist_full_reg <= 1'b0;
            wr_ptr_reg    <= 2'd0;
        end else if (accept) begin
            if (!hist_full_reg) begin
                for (int i = 0; i < 4; i++) begin
                    hist_reg[i] <= bus.temp_raw;
                end
                hist_full_reg <= 1'b1;
            end else begin
                hist_reg[wr_ptr_reg] <= bus.temp_raw;
                wr_ptr_reg           <= wr_ptr_reg + 2'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
`ifdef TEMP_AVG_EN
                    state_next = S_AVG;
`else
                    state_next = S_ABS;
`endif
                end
            end
            S_AVG:   state_next = S_ABS;
            S_ABS:   state_next = S_MUL;
            S_MUL:   state_next = (cnt_reg == 3'd0) ? S_OUT : S_MUL;
            S_OUT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_reg       <= '0;
            mag_reg       <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            neg_pend_reg  <= 1'b0;
            err_pend_reg  <= 1'b0;
            seg_value_reg <= '0;
            dot_reg       <= 6'b111111;
            neg_reg       <= 1'b0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            upd_reg       <= 1'b0;
        end else begin
            upd_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        raw_reg  <= bus.temp_raw;
                        busy_reg <= 1'b1;
                    end
                end
                S_AVG: begin
`ifdef TEMP_AVG_EN
                    // Arithmetic shift right by 2 == floor of sum / 4.
                    raw_reg <= hist_sum[17:2];
`endif
                end
                S_ABS: begin
                    // Sign and clamp flag are held back until OUT so that
                    // every visible output changes on the same edge.
                    neg_pend_reg <= raw_reg[15];
                    if (over) begin
                        mag_reg      <= MAG_MAX_W[10:0];
                        err_pend_reg <= 1'b1;
                    end else begin
                        mag_reg      <= mag_full[10:0];
                        err_pend_reg <= 1'b0;
                    end
                    acc_reg <= '0;
                    cnt_reg <= 3'd6;
                end
                S_MUL: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg - 3'd1;
                end
                S_OUT: begin
                    // Dropping acc[0] turns x125 into x62.5, truncating.
                    seg_value_reg <= {8'd0, acc_reg[17:1]};
                    dot_reg       <= 6'b111011;
                    neg_reg       <= neg_pend_reg;
                    err_reg       <= err_pend_reg;
                    upd_reg       <= 1'b1;
                    busy_reg      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.seg_value = seg_value_reg;
    assign bus.dot       = dot_reg;
    assign bus.neg       = neg_reg;
    assign bus.err       = err_reg;
    assign bus.busy      = busy_reg;
    assign bus.upd       = upd_reg;

endmodule
